// File: rtl/matrix_multiply_unit.sv
// rtl/matrix_multiply_unit.sv - sequential signed C = A x B, one MAC per cycle, start/busy/done handshake
// Optional saturating accumulation: define MATMUL_ACC_SAT_EN.
module matrix_multiply_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int M_ROWS     = 2,
  parameter int K_DIM      = 3,
  parameter int N_COLS     = 2,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_start_matmul,
  input  logic signed [DATA_WIDTH-1:0] input_matrix_a  [0:M_ROWS-1][0:K_DIM-1],
  input  logic signed [DATA_WIDTH-1:0] input_matrix_b  [0:K_DIM-1][0:N_COLS-1],
  output logic signed [ACC_WIDTH-1:0]  output_matrix_c [0:M_ROWS-1][0:N_COLS-1],
  output logic                         op_busy_matmul,
  output logic                         op_done_matmul
);

  localparam int IW = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
  localparam int JW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int KW = (K_DIM  > 1) ? $clog2(K_DIM)  : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_t;

  state_t state, state_next;

  logic signed [DATA_WIDTH-1:0] a_reg [0:M_ROWS-1][0:K_DIM-1];
  logic signed [DATA_WIDTH-1:0] b_reg [0:K_DIM-1][0:N_COLS-1];
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic signed [ACC_WIDTH-1:0] acc, a_ext, b_ext, prod, sum;
  logic last_i, last_j, last_k;

  assign last_i = (i == IW'(M_ROWS - 1));
  assign last_j = (j == JW'(N_COLS - 1));
  assign last_k = (k == KW'(K_DIM - 1));

  always_comb begin
    a_ext = ACC_WIDTH'(a_reg[i][k]);
    b_ext = ACC_WIDTH'(b_reg[k][j]);
    prod  = a_ext * b_ext;
  end

`ifdef MATMUL_ACC_SAT_EN
  // One guard bit: the two top bits disagree exactly when acc+prod overflowed.
  logic signed [ACC_WIDTH:0] sum_wide;
  always_comb begin
    sum_wide = {acc[ACC_WIDTH-1], acc} + {prod[ACC_WIDTH-1], prod};
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sum = sum_wide[ACC_WIDTH-1:0];
  end
`else
  assign sum = acc + prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    op_busy_matmul = 1'b0;
    op_done_matmul = 1'b0;
    case (state)
      S_IDLE: if (op_start_matmul) state_next = S_LOAD;
      S_LOAD: begin
        op_busy_matmul = 1'b1;
        state_next     = S_MAC;
      end
      S_MAC: begin
        op_busy_matmul = 1'b1;
        if (last_k && last_j && last_i) state_next = S_DONE;
      end
      S_DONE: begin
        op_done_matmul = 1'b1;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operands are snapshotted once so upstream may change the ports mid-operation.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      a_reg <= input_matrix_a;
      b_reg <= input_matrix_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      for (int r = 0; r < M_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          output_matrix_c[r][c] <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          acc <= '0;
          i   <= '0;
          j   <= '0;
          k   <= '0;
        end
        S_MAC: begin
          if (!last_k) begin
            acc <= sum;
            k   <= k + 1'b1;
          end else begin
            output_matrix_c[i][j] <= sum;
            acc <= '0;
            k   <= '0;
            if (last_j) begin
              j <= '0;
              i <= last_i ? '0 : i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
